turn_queue: RTL

- Sits directly upstream of the snake head/motion block.
- Converts the raw keyboard keycode (level, held as long as the key is down) into a clean, spaced stream of direction commands on frame_clk.
- Press edge detection, same-axis rejection, a small FIFO so fast key sequences (e.g. W then D within one frame gap) are not lost, and fixed HOLD/GAP timing so the head sees each turn as a level for a bounded number of frames.

---
 rtl/turn_queue.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/turn_queue.sv
// Keyboard-to-head direction command queue: press edge detection, same-axis
// rejection, small FIFO, and fixed hold/gap spacing of emitted commands.
module turn_queue #(
  parameter int DEPTH       = 4,
  parameter int HOLD_FRAMES = 2,
  parameter int GAP_FRAMES  = 6
) (
  input  logic                     frame_clk,
  input  logic                     Reset,
  input  logic [7:0]               keycode_in,
  input  logic                     halt,
  output logic [7:0]               keycode_out,
  output logic [$clog2(DEPTH):0]   q_count,
  output logic                     q_full,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam int GW = (GAP_FRAMES > 1) ? $clog2(GAP_FRAMES) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_FRAMES - 1);
  localparam logic [GW-1:0] GAP_LOAD  = (GAP_FRAMES > 0) ? GW'(GAP_FRAMES - 1) : '0;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef enum logic [1:0] {AXIS_NONE, AXIS_X, AXIS_Y} axis_t;
  typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;

  function automatic axis_t axis_of(input logic [7:0] key);
    case (key)
      8'h04, 8'h07: return AXIS_X;
      8'h16, 8'h1A: return AXIS_Y;
      default:      return AXIS_NONE;
    endcase
  endfunction

  logic [7:0]    mem [DEPTH];
  logic [7:0]    prev_key;
  axis_t         last_axis;
  state_t        state, state_next;
  logic [HW-1:0] hold_cnt, hold_next;
  logic [GW-1:0] gap_cnt, gap_next;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count_next;
  logic [7:0]    out_next;
  axis_t         key_axis;
  logic          press, accept, pop, push, drop;

  always_comb begin
    key_axis = axis_of(keycode_in);
    press    = (key_axis != AXIS_NONE) && (keycode_in != prev_key);
    accept   = press && (key_axis != last_axis) && !halt;
    // Pop decision uses the registered occupancy, so a fresh push never bypasses.
    pop      = !halt && (state == IDLE) && (q_count != '0);
    push     = accept && ((q_count != FULL_COUNT) || pop);
    drop     = accept && !push;
    count_next = q_count;
    case ({push, pop})
      2'b10:   count_next = q_count + 1'b1;
      2'b01:   count_next = q_count - 1'b1;
      default: count_next = q_count;
    endcase
  end

  always_comb begin
    state_next = state;
    hold_next  = hold_cnt;
    gap_next   = gap_cnt;
    out_next   = keycode_out;
    if (halt) begin
      state_next = IDLE;
      out_next   = 8'h00;
    end else begin
      case (state)
        IDLE: begin
          out_next = 8'h00;
          if (pop) begin
            out_next   = mem[rd_ptr];
            hold_next  = HOLD_LOAD;
            state_next = DRIVE;
          end
        end
        DRIVE: begin
          if (hold_cnt == '0) begin
            out_next = 8'h00;
            if (GAP_FRAMES == 0) begin
              state_next = IDLE;
            end else begin
              state_next = GAP;
              gap_next   = GAP_LOAD;
            end
          end else begin
            hold_next = hold_cnt - 1'b1;
          end
        end
        GAP: begin
          out_next = 8'h00;
          if (gap_cnt == '0) state_next = IDLE;
          else               gap_next   = gap_cnt - 1'b1;
        end
        default: begin
          state_next = IDLE;
          out_next   = 8'h00;
        end
      endcase
    end
  end

  // Storage has no reset so it can map onto distributed/block RAM.
  always_ff @(posedge frame_clk) begin
    if (push) mem[wr_ptr] <= keycode_in;
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      prev_key    <= 8'h00;
      last_axis   <= AXIS_NONE;
      state       <= IDLE;
      hold_cnt    <= '0;
      gap_cnt     <= '0;
      keycode_out <= 8'h00;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      q_count     <= '0;
      q_full      <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      prev_key    <= keycode_in;
      state       <= state_next;
      hold_cnt    <= hold_next;
      gap_cnt     <= gap_next;
      keycode_out <= out_next;
      overflow    <= drop;
      if (halt) begin
        last_axis <= AXIS_NONE;
        rd_ptr    <= '0;
        wr_ptr    <= '0;
        q_count   <= '0;
        q_full    <= 1'b0;
      end else begin
        if (accept) last_axis <= key_axis;
        if (push)   wr_ptr <= wr_ptr + 1'b1;
        if (pop)    rd_ptr <= rd_ptr + 1'b1;
        q_count <= count_next;
        q_full  <= (count_next == FULL_COUNT);
      end
    end
  end

endmodule
